inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage directly upstream of the decode stage in the RISC-V SoC core. It owns the program counter, issues word reads to the instruction ROM (1-cycle synchronous read latency), and buffers returned words in a 2-entry queue. It presents {instruction, address, valid} to decode under a hold (stall) handshake. Redirects from execute (jump/branch taken) flush in-flight and buffered fetches and restart at the target address.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset release.
- NOP_INST, 32'h0000_0013: bubble encoding (addi x0,x0,0) driven on inst_o when not valid.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; the block is in reset while rst=0.
- rom_req_o  out  1  ROM read strobe; one request per cycle max.
- rom_addr_o  out  32  byte address of request; always word-aligned; ROM indexes [31:2].
- rom_data_i  in  32  ROM read data, valid exactly 1 cycle after a cycle with rom_req_o=1.
- jump_en_i  in  1  redirect request from execute, single-cycle pulse.
- jump_addr_i  in  32  redirect target; bits [1:0] ignored, treated as 0.
- hold_i  in  1  decode cannot accept; head entry must be held stable.
- inst_o  out  32  instruction to decode; NOP_INST when inst_valid_o=0.
- inst_addr_o  out  32  address of inst_o; 0 when inst_valid_o=0.
- inst_valid_o  out  1  head entry valid.

## Operation
- State: pc (next issue address), inflight (1 bit), inflight_kill (1 bit), 2-entry queue {inst, addr} with count 0..2.
- Issue condition (no jump): rst=1 and (count + inflight − pop) < 2, where pop = inst_valid_o & ~hold_i. When issuing: rom_req_o=1, rom_addr_o=pc, pc <= pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
- rom_addr_o = pc when not issuing (don't-care, but must be stable).
- Response: cycle after an issue, rom_data_i with its issue address is pushed into the queue unless inflight_kill=1, in which case it is discarded.
- Pop: head retires when inst_valid_o=1 and hold_i=0 at the clock edge.
- Push and pop in the same cycle are legal at count=1 or 2; count never exceeds 2; no push ever occurs at count=2 (guaranteed by issue condition).
- Jump (jump_en_i=1) has priority over hold_i and pop: queue cleared (count <= 0); any in-flight response marked kill; same cycle rom_req_o=1, rom_addr_o={jump_addr_i[31:2],2'b00}, pc <= that +4. The redirect request is never killed.
- Back-to-back jumps: each cycle's jump kills the previous cycle's redirect request; last one wins.
- Outputs driven from queue head registers only (no combinational path from rom_data_i or jump_en_i to inst_*).

## Timing
- Reset (rst=0): pc=RESET_PC, count=0, inflight=0, inflight_kill=0; outputs rom_req_o=0, rom_addr_o=RESET_PC, inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0.
- First cycle with rst=1: rom_req_o=1, rom_addr_o=RESET_PC.
- Fetch latency: request in cycle t -> data on rom_data_i in t+1 -> inst_valid_o=1 in t+2.
- Steady state with hold_i=0: one instruction per cycle, consecutive addresses.
- Jump at t: inst_valid_o=0 at t+1 (queue flushed), target instruction valid at t+2; 1-cycle bubble.
- hold_i asserted: at most 2 entries accumulate; rom_req_o drops to 0 while count+inflight=2; after hold_i deasserts, issuing resumes the same cycle.
- Reset asserted mid-operation: all state cleared asynchronously; in-flight ROM response after release ignored (inflight=0).

## Structure
- Shared core package: NOP_INST, RESET_PC defaults, XLEN=32.
- One sub-module: fetch_queue (2-entry FIFO, push/pop/flush, count, head outputs). PC, issue and kill logic live in inst_fetch.

## Test plan
- Reset release, ROM = addr/4, hold_i=0 -> first request 0x0 at cycle 1; inst_valid_o at cycle 3 with inst_o=0, inst_addr_o=0; then 0x4, 0x8 each consecutive cycle.
- hold_i=1 for 5 cycles during streaming -> inst_o/inst_addr_o frozen, rom_req_o=0 after 2 buffered, no address skipped or duplicated on release.
- Jump to 0x100 at cycle t during streaming -> rom_addr_o=0x100 at t, inst_valid_o=0 at t+1, inst_addr_o=0x100 at t+2, 0x104 at t+3; pre-jump words never appear.
- Jump with hold_i=1 and queue full -> queue flushed, target 0x200 delivered at t+2.
- Jumps to 0x40 then 0x80 on consecutive cycles -> 0x40 never delivered; 0x80 at t+3.
- Reset pulse (rst=0 for 1 cycle) mid-stream with pending data -> outputs return to reset values immediately; after release fetching restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared core constants and the fetch queue entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inst_fetch_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- the bubble shown to decode when nothing is valid.
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // One buffered fetch: the returned word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
  } fq_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction buffer between the ROM response and decode.
// Latency: a push is visible at the head on the next cycle; head outputs are registered.
// Backpressure: the caller never pushes when full; pop is gated by the caller's hold.
//
// Ports: clk, rst (async active-low), flush (drops all entries, beats push/pop),
//        push/push_dat (new entry), pop (retire head), head_vld/head_inst/head_addr,
//        count (0..2 entries held).
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  fq_entry_t       push_dat,
  input  logic            pop,
  output logic            head_vld,
  output logic [XLEN-1:0] head_inst,
  output logic [XLEN-1:0] head_addr,
  output logic [1:0]      count
);

  // e0 is always the head; e1 is only meaningful when count == 2.
  fq_entry_t e0;
  fq_entry_t e1;
  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_dat;
          else             e1 <= push_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever stays.
          if (cnt == 2'd1) begin
            e0 <= push_dat;
          end else begin
            e0 <= e1;
            e1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign count     = cnt;
  assign head_vld  = (cnt != 2'd0);
  assign head_inst = head_vld ? e0.inst : NOP_INST;
  assign head_addr = head_vld ? e0.addr : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues ROM word reads, buffers returns for decode.
// Latency: request at t, ROM data at t+1, instruction valid to decode at t+2.
// Backpressure: hold_i freezes the head; issuing stops once buffered + in-flight reaches 2.
//
// Ports: clk, rst (async active-low); rom_req_o/rom_addr_o/rom_data_i (1-cycle ROM);
//        jump_en_i/jump_addr_i (redirect from execute); hold_i (decode stall);
//        inst_o/inst_addr_o/inst_valid_o (head of the fetch queue).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_req_o,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic [XLEN-1:0] rom_data_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            inst_valid_o
);

  logic [XLEN-1:0] pc;        // next sequential issue address
  logic [XLEN-1:0] req_addr;  // address of the request currently in flight
  logic            inflight;  // a ROM response lands this cycle
  logic [1:0]      count;
  logic [2:0]      occ;
  logic            pop;
  logic            jump;
  logic            issue;
  logic            push;
  logic [XLEN-1:0] jump_tgt;
  fq_entry_t       push_dat;

  assign jump     = rst & jump_en_i;
  assign jump_tgt = word_align(jump_addr_i);
  assign pop      = inst_valid_o & ~hold_i;

  // Slots committed after this edge must stay below 2 so a response
  // always has room when it arrives.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = rst & (occ < 3'd2);

  assign rom_req_o  = jump | issue;
  assign rom_addr_o = jump ? jump_tgt : pc;

  // The response to any older request arrives in the very cycle a jump is
  // seen, so killing it reduces to dropping the push in that cycle. The
  // redirect's own response arrives a cycle later and is kept unless a
  // second jump lands in that cycle.
  assign push          = inflight & ~jump_en_i;
  assign push_dat.inst = rom_data_i;
  assign push_dat.addr = req_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= rom_req_o;
      if (rom_req_o) begin
        pc       <= rom_addr_o + 32'd4;
        req_addr <= rom_addr_o;
      end
    end
  end

  fetch_queue #(
    .NOP_INST(NOP_INST)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (jump),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_vld (inst_valid_o),
    .head_inst(inst_o),
    .head_addr(inst_addr_o),
    .count    (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a 1-cycle ROM whose word at addr is addr/4.
// Latency: n/a.
// Backpressure: hold_i driven directly by the step sequence.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int n_cmp;
  int n_bad;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .hold_i      (hold_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .inst_valid_o(inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word index as data; garbage when no request was made.
  always @(posedge clk)
    rom_data_i <= rom_req_o ? (rom_addr_o >> 2) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs away from the edge, let logic settle.
  task automatic step(input logic h, input logic je, input logic [31:0] ja);
    @(posedge clk);
    #2;
    hold_i      = h;
    jump_en_i   = je;
    jump_addr_i = ja;
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b0;
    hold_i      = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = 32'h0;
    #3;
    chk("rst_req",   {31'b0, rom_req_o},    32'd0);
    chk("rst_addr",  rom_addr_o,            32'h0);
    chk("rst_inst",  inst_o,                32'h0000_0013);
    chk("rst_iaddr", inst_addr_o,           32'h0);
    chk("rst_vld",   {31'b0, inst_valid_o}, 32'd0);

    // C1: reset released
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("c1_req",  {31'b0, rom_req_o},    32'd1);
    chk("c1_addr", rom_addr_o,            32'h0);
    chk("c1_vld",  {31'b0, inst_valid_o}, 32'd0);
    step(0, 0, 0); // C2
    chk("c2_addr", rom_addr_o,            32'h4);
    chk("c2_vld",  {31'b0, inst_valid_o}, 32'd0);
    step(0, 0, 0); // C3
    chk("c3_vld",   {31'b0, inst_valid_o}, 32'd1);
    chk("c3_inst",  inst_o,                32'h0);
    chk("c3_iaddr", inst_addr_o,           32'h0);
    chk("c3_addr",  rom_addr_o,            32'h8);
    step(0, 0, 0); // C4
    chk("c4_iaddr", inst_addr_o, 32'h4);
    chk("c4_inst",  inst_o,      32'h1);
    step(0, 0, 0); // C5
    chk("c5_iaddr", inst_addr_o, 32'h8);
    chk("c5_addr",  rom_addr_o,  32'h10);

    // C6..C10: decode stalls; head 0xC frozen, 0x10 fills the second slot
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("hold_iaddr", inst_addr_o,        32'hC);
      chk("hold_inst",  inst_o,             32'h3);
      chk("hold_req",   {31'b0, rom_req_o}, 32'd0);
    end
    step(0, 0, 0); // C11: release, issue resumes same cycle
    chk("rel_req",   {31'b0, rom_req_o}, 32'd1);
    chk("rel_addr",  rom_addr_o,         32'h14);
    chk("rel_iaddr", inst_addr_o,        32'hC);
    step(0, 0, 0); // C12
    chk("c12_iaddr", inst_addr_o, 32'h10);
    step(0, 0, 0); // C13
    chk("c13_iaddr", inst_addr_o, 32'h14);
    step(0, 0, 0); // C14
    chk("c14_iaddr", inst_addr_o, 32'h18);

    // C15: jump to 0x103 (low bits ignored)
    step(0, 1, 32'h0000_0103);
    chk("j1_req",  {31'b0, rom_req_o}, 32'd1);
    chk("j1_addr", rom_addr_o,         32'h100);
    step(0, 0, 0); // C16
    chk("j1_bubble", {31'b0, inst_valid_o}, 32'd0);
    chk("j1_next",   rom_addr_o,            32'h104);
    step(0, 0, 0); // C17
    chk("j1_vld",   {31'b0, inst_valid_o}, 32'd1);
    chk("j1_iaddr", inst_addr_o,           32'h100);
    chk("j1_inst",  inst_o,                32'h40);
    step(0, 0, 0); // C18
    chk("j1_iaddr2", inst_addr_o, 32'h104);
    chk("j1_inst2",  inst_o,      32'h41);

    // Fill the queue under hold, then jump while held
    step(1, 0, 0); // C19
    chk("fill_req", {31'b0, rom_req_o}, 32'd0);
    step(1, 0, 0); // C20
    chk("full_req",   {31'b0, rom_req_o}, 32'd0);
    chk("full_iaddr", inst_addr_o,        32'h108);
    step(1, 1, 32'h200); // C21
    chk("j2_addr", rom_addr_o, 32'h200);
    step(0, 0, 0); // C22
    chk("j2_bubble", {31'b0, inst_valid_o}, 32'd0);
    step(0, 0, 0); // C23
    chk("j2_iaddr", inst_addr_o, 32'h200);
    chk("j2_inst",  inst_o,      32'h80);

    // Back-to-back jumps: 0x40 then 0x80
    step(0, 1, 32'h40); // C24
    chk("bb_addr1", rom_addr_o, 32'h40);
    step(0, 1, 32'h80); // C25
    chk("bb_addr2", rom_addr_o,            32'h80);
    chk("bb_vld25", {31'b0, inst_valid_o}, 32'd0);
    step(0, 0, 0); // C26
    chk("bb_vld26", {31'b0, inst_valid_o}, 32'd0);
    step(0, 0, 0); // C27
    chk("bb_iaddr", inst_addr_o, 32'h80);
    chk("bb_inst",  inst_o,      32'h20);
    step(0, 0, 0); // C28
    chk("bb_iaddr2", inst_addr_o, 32'h84);
    step(0, 0, 0); // C29
    chk("pre_rst_vld", {31'b0, inst_valid_o}, 32'd1);

    // Asynchronous reset pulse mid-stream
    rst = 1'b0;
    #1;
    chk("arst_vld",   {31'b0, inst_valid_o}, 32'd0);
    chk("arst_inst",  inst_o,                32'h0000_0013);
    chk("arst_iaddr", inst_addr_o,           32'h0);
    chk("arst_req",   {31'b0, rom_req_o},    32'd0);
    chk("arst_addr",  rom_addr_o,            32'h0);
    @(posedge clk);
    #2 rst = 1'b1; // C30
    #1;
    chk("rr_req",  {31'b0, rom_req_o},    32'd1);
    chk("rr_addr", rom_addr_o,            32'h0);
    chk("rr_vld",  {31'b0, inst_valid_o}, 32'd0);
    step(0, 0, 0); // C31
    chk("rr_vld31", {31'b0, inst_valid_o}, 32'd0);
    step(0, 0, 0); // C32
    chk("rr_iaddr", inst_addr_o, 32'h0);
    chk("rr_inst",  inst_o,      32'h0);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC); // C33
    chk("wr_addr", rom_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 0); // C34
    chk("wr_next", rom_addr_o, 32'h0);
    step(0, 0, 0); // C35
    chk("wr_iaddr", inst_addr_o, 32'hFFFF_FFFC);
    chk("wr_inst",  inst_o,      32'h3FFF_FFFF);
    step(0, 0, 0); // C36
    chk("wr_iaddr2", inst_addr_o, 32'h0);
    chk("wr_inst2",  inst_o,      32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
